alu_seq: RTL and testbench

- Sequencer on the issue side of the ALU. It drives `alu`'s operand, shamt and aluop inputs, and consumes its `res` and `flags` outputs.
- Accepts one operation per valid/ready handshake and runs one or two ALU passes. SUB needs two passes because the ALU has no carry-in.
- Holds the result until the consumer accepts it, owns the architectural NZVC flag register, and evaluates LEGv8 B.cond conditions.

---
 rtl/alu_seq_pkg.sv | 56 +++++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_seq_cond_eval.sv | 27 ++
 rtl/alu_seq.sv | 158 +++++++++++++++
 tb/tb_alu_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the ALU issue sequencer
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_ORR = 3'd1,
    OP_EOR = 3'd2,
    OP_ADD = 3'd3,
    OP_SUB = 3'd4,
    OP_LSL = 3'd5,
    OP_LSR = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_P1   = 2'd1,
    ST_P2   = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    AOP_AND = 2'd0,
    AOP_ORR = 2'd1,
    AOP_ADD = 2'd2,
    AOP_EOR = 2'd3
  } aop_e;

  localparam int ALUOP_INVA  = 5;
  localparam int ALUOP_INVB  = 4;
  localparam int ALUOP_SHIFT = 3;
  localparam int ALUOP_SHDIR = 2;

  function automatic logic [5:0] mk_aluop(input logic inva, input logic invb,
                                          input logic shift, input logic left,
                                          input aop_e op);
    logic [5:0] r;
    r = '0;
    r[ALUOP_INVA]  = inva;
    r[ALUOP_INVB]  = invb;
    r[ALUOP_SHIFT] = shift;
    r[ALUOP_SHDIR] = left;
    r[1:0]         = op;
    return r;
  endfunction

  function automatic aop_e aop_of(input op_e op);
    case (op)
      OP_ORR:  return AOP_ORR;
      OP_EOR:  return AOP_EOR;
      OP_ADD:  return AOP_ADD;
      default: return AOP_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation request and result handshake bundle
interface alu_seq_if #(
  parameter int WORDSIZE  = 64,
  parameter int SHAMTSIZE = 6
);
  logic                 in_valid;
  logic                 in_ready;
  logic [2:0]           in_op;
  logic [WORDSIZE-1:0]  in_a;
  logic [WORDSIZE-1:0]  in_b;
  logic [SHAMTSIZE-1:0] in_shamt;
  logic                 in_setflags;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORDSIZE-1:0]  out_res;

  modport master (
    output in_valid, in_op, in_a, in_b, in_shamt, in_setflags, out_ready,
    input  in_ready, out_valid, out_res
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_shamt, in_setflags, out_ready,
    output in_ready, out_valid, out_res
  );
endinterface

// File: rtl/alu_seq_cond_eval.sv
// rtl/alu_seq_cond_eval.sv - LEGv8 B.cond evaluation against NZVC
// Instantiated by alu_seq only when ALU_SEQ_COND_EN is defined.
module alu_seq_cond_eval (
  input  logic [3:0] cond,
  input  logic [3:0] nzvc,
  output logic       cond_true
);
  logic n, z, v, c, base;

  assign {n, z, v, c} = nzvc;

  // Odd codes are the negation of the even code below them, except 15 (always).
  always_comb begin
    base = 1'b1;
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    cond_true = (cond[0] && (cond[3:1] != 3'd7)) ? ~base : base;
  end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - ALU issue sequencer: handshake, one/two ALU passes, NZVC register
// Condition evaluator is built only with ALU_SEQ_COND_EN defined.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WORDSIZE  = 64,
  parameter int SHAMTSIZE = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_seq_if.slave             bus,
  output logic [WORDSIZE-1:0]  alu_a,
  output logic [WORDSIZE-1:0]  alu_b,
  output logic [SHAMTSIZE-1:0] alu_shamt,
  output logic [5:0]           alu_aluop,
  input  logic [WORDSIZE-1:0]  alu_res,
  input  logic [3:0]           alu_flags,
  output logic [3:0]           nzvc,
  input  logic [3:0]           cond,
  output logic                 cond_true
);
  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [WORDSIZE-1:0]  a_q, a_d, b_q, b_d, t_q, t_d, res_q, res_d;
  logic [SHAMTSIZE-1:0] shamt_q, shamt_d;
  logic                 setf_q, setf_d, c1_q, c1_d;
  logic [3:0]           nzvc_q, nzvc_d;
  logic                 res_msb, res_zero, sub_v;

  assign res_msb  = alu_res[WORDSIZE-1];
  assign res_zero = (alu_res == '0);
  // Signed overflow of a - b: operand signs differ and result sign differs from a.
  assign sub_v    = (a_q[WORDSIZE-1] != b_q[WORDSIZE-1]) && (res_msb != a_q[WORDSIZE-1]);

  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out_res   = res_q;
  assign nzvc          = nzvc_q;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    shamt_d   = shamt_q;
    setf_d    = setf_q;
    t_d       = t_q;
    c1_d      = c1_q;
    res_d     = res_q;
    nzvc_d    = nzvc_q;
    alu_a     = '0;
    alu_b     = '0;
    alu_shamt = '0;
    alu_aluop = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          op_d    = op_e'(bus.in_op);
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          shamt_d = bus.in_shamt;
          setf_d  = bus.in_setflags;
          state_d = ST_P1;
        end
      end
      ST_P1: begin
        case (op_q)
          OP_SUB: begin
            // First pass t = ~a + b; its carry-out is the inverse of the borrow-free flag.
            alu_a     = a_q;
            alu_b     = b_q;
            alu_aluop = mk_aluop(1'b1, 1'b0, 1'b0, 1'b0, AOP_ADD);
            t_d       = alu_res;
            c1_d      = alu_flags[0];
            state_d   = ST_P2;
          end
          OP_LSL, OP_LSR: begin
            alu_a     = a_q;
            alu_shamt = shamt_q;
            alu_aluop = mk_aluop(1'b0, 1'b0, 1'b1, op_q == OP_LSL, AOP_ORR);
            res_d     = alu_res;
            state_d   = ST_OUT;
          end
          OP_RSV: begin
            alu_aluop = mk_aluop(1'b0, 1'b0, 1'b0, 1'b0, AOP_AND);
            res_d     = alu_res;
            state_d   = ST_OUT;
          end
          default: begin
            alu_a     = a_q;
            alu_b     = b_q;
            alu_aluop = mk_aluop(1'b0, 1'b0, 1'b0, 1'b0, aop_of(op_q));
            res_d     = alu_res;
            state_d   = ST_OUT;
            if (setf_q) begin
              nzvc_d = (op_q == OP_ADD) ? alu_flags : {res_msb, res_zero, 2'b00};
            end
          end
        endcase
      end
      ST_P2: begin
        // ~t & ~t = ~(~a + b) = a - b.
        alu_a     = t_q;
        alu_b     = t_q;
        alu_aluop = mk_aluop(1'b1, 1'b1, 1'b0, 1'b0, AOP_AND);
        res_d     = alu_res;
        state_d   = ST_OUT;
        if (setf_q) begin
          nzvc_d = {res_msb, res_zero, sub_v, ~c1_q};
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_AND;
      a_q     <= '0;
      b_q     <= '0;
      shamt_q <= '0;
      setf_q  <= 1'b0;
      t_q     <= '0;
      c1_q    <= 1'b0;
      res_q   <= '0;
      nzvc_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      shamt_q <= shamt_d;
      setf_q  <= setf_d;
      t_q     <= t_d;
      c1_q    <= c1_d;
      res_q   <= res_d;
      nzvc_q  <= nzvc_d;
    end
  end

`ifdef ALU_SEQ_COND_EN
  alu_seq_cond_eval u_cond_eval (
    .cond      (cond),
    .nzvc      (nzvc_q),
    .cond_true (cond_true)
  );
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign cond_true   = 1'b0;
`endif
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq with a behavioural ALU and transaction model
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] alu_a, alu_b, alu_res;
  logic [5:0]  alu_shamt, alu_aluop;
  logic [3:0]  alu_flags, nzvc, cond;
  logic        cond_true;
  int          n_cmp = 0;
  int          n_bad = 0;

  alu_seq_if #(.WORDSIZE(64), .SHAMTSIZE(6)) bus ();

  alu_seq #(.WORDSIZE(64), .SHAMTSIZE(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_shamt (alu_shamt),
    .alu_aluop (alu_aluop),
    .alu_res   (alu_res),
    .alu_flags (alu_flags),
    .nzvc      (nzvc),
    .cond      (cond),
    .cond_true (cond_true)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: optional operand inversion, op, then optional shift.
  logic [63:0] ax, ay, ar;
  logic [64:0] asum;
  always_comb begin
    ax   = alu_aluop[5] ? ~alu_a : alu_a;
    ay   = alu_aluop[4] ? ~alu_b : alu_b;
    asum = {1'b0, ax} + {1'b0, ay};
    case (alu_aluop[1:0])
      2'd0:    ar = ax & ay;
      2'd1:    ar = ax | ay;
      2'd2:    ar = asum[63:0];
      default: ar = ax ^ ay;
    endcase
    if (alu_aluop[3]) ar = alu_aluop[2] ? (ar << alu_shamt) : (ar >> alu_shamt);
    alu_res   = ar;
    alu_flags = {ar[63], ar == 64'd0, 2'b00};
    if (alu_aluop[1:0] == 2'd2)
      alu_flags[1:0] = {(ax[63] == ay[63]) && (ar[63] != ax[63]), asum[64]};
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation, straight from the operation definitions.
  task automatic model_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          input logic [5:0] sh, input logic setf, input logic [3:0] cur,
                          output logic [63:0] r, output logic [3:0] f);
    logic [64:0] wide;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    f = cur;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: begin
        wide = {1'b0, a} + {1'b0, b};
        r = wide[63:0];
        c = wide[64];
        v = (a[63] == b[63]) && (r[63] != a[63]);
      end
      3'd4: begin
        r = a - b;
        c = (a >= b);
        v = (a[63] != b[63]) && (r[63] != a[63]);
      end
      3'd5: r = a << sh;
      3'd6: r = a >> sh;
      default: r = 64'd0;
    endcase
    if (setf && op <= 3'd4) f = {r[63], r == 64'd0, v, c};
  endtask

  function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, v, cy;
    {n, z, v, cy} = f;
`ifdef ALU_SEQ_COND_EN
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !(cy && !z);
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return !(!z && (n == v));
      default: return 1'b1;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Transaction model: busy from accept until the result is taken.
  bit          m_busy  = 1'b0;
  bit          m_valid = 1'b0;
  int          m_cnt   = 0;
  logic [63:0] m_res   = '0;
  logic [63:0] p_res   = '0;
  logic [3:0]  m_nzvc  = '0;
  logic [3:0]  p_nzvc  = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_valid = 1'b0; m_cnt = 0; m_nzvc = 4'd0;
    end else if (m_valid) begin
      if (bus.out_ready) begin m_valid = 1'b0; m_busy = 1'b0; end
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin m_valid = 1'b1; m_res = p_res; m_nzvc = p_nzvc; end
    end else if (bus.in_valid) begin
      model_op(bus.in_op, bus.in_a, bus.in_b, bus.in_shamt, bus.in_setflags, m_nzvc, p_res, p_nzvc);
      m_busy = 1'b1;
      m_cnt  = (bus.in_op == 3'd4) ? 2 : 1;
    end
  end

  always @(negedge clk) begin
    check("in_ready", 64'(bus.in_ready), 64'(!m_busy && !rst));
    check("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) check("out_res", bus.out_res, m_res);
    check("nzvc", 64'(nzvc), 64'(m_nzvc));
    check("cond_true", 64'(cond_true), 64'(exp_cond(cond, m_nzvc)));
  end

  task automatic accept_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [5:0] sh, input logic setf);
    int w;
    @(posedge clk); #2;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    bus.in_shamt = sh; bus.in_setflags = setf;
    w = 0;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
    check("accept in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_op(input logic [63:0] exp_res, input logic [3:0] exp_nzvc,
                           input int exp_lat, input int hold);
    int   lat;
    logic seen;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk); seen = bus.out_valid;
      @(posedge clk); lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    #2;
    if (hold > 0) begin bus.in_valid = 1'b1; bus.in_op = 3'd3; bus.in_a = 64'd77; end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      check("lit out_valid", 64'(bus.out_valid), 64'd1);
      check("lit out_res", bus.out_res, exp_res);
      check("lit nzvc", 64'(nzvc), 64'(exp_nzvc));
      if (hold > 0) check("hold in_ready", 64'(bus.in_ready), 64'd0);
    end
    @(posedge clk); #2;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #2;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [5:0] sh, input logic setf,
                        input logic [63:0] exp_res, input logic [3:0] exp_nzvc, input int hold);
    accept_op(op, a, b, sh, setf);
    finish_op(exp_res, exp_nzvc, (op == 3'd4) ? 3 : 2, hold);
  endtask

  task automatic check_cond(input logic [3:0] c, input logic e);
    @(posedge clk); #2;
    cond = c;
    @(negedge clk);
`ifdef ALU_SEQ_COND_EN
    check("lit cond_true", 64'(cond_true), 64'(e));
`else
    check("lit cond_true", 64'(cond_true), 64'(e & 1'b0));
`endif
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = '0; bus.in_b = '0;
    bus.in_shamt = '0; bus.in_setflags = 1'b0; bus.out_ready = 1'b0; cond = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_res", bus.out_res, 64'd0);
    check("rst nzvc", 64'(nzvc), 64'd0);
    check("rst in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle in_ready", 64'(bus.in_ready), 64'd1);

    run_op(3'd4, 64'd5, 64'd3, 6'd0, 1'b1, 64'd2, 4'b0001, 0);
    check_cond(4'd2, 1'b1);
    check_cond(4'd3, 1'b0);
    check_cond(4'd8, 1'b1);
    run_op(3'd4, 64'd3, 64'd5, 6'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 0);
    check_cond(4'd11, 1'b1);
    check_cond(4'd2, 1'b0);
    check_cond(4'd4, 1'b1);
    run_op(3'd3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 6'd0, 1'b1, 64'h8000_0000_0000_0000, 4'b1010, 0);
    check_cond(4'd6, 1'b1);
    check_cond(4'd10, 1'b1);
    check_cond(4'd8, 1'b0);
    run_op(3'd0, 64'hF0, 64'h0F, 6'd0, 1'b1, 64'd0, 4'b0100, 0);
    check_cond(4'd0, 1'b1);
    check_cond(4'd1, 1'b0);
    check_cond(4'd12, 1'b0);
    check_cond(4'd13, 1'b1);
    check_cond(4'd15, 1'b1);
    run_op(3'd5, 64'd1, 64'd0, 6'd63, 1'b1, 64'h8000_0000_0000_0000, 4'b0100, 0);
    run_op(3'd6, 64'h80, 64'd0, 6'd4, 1'b0, 64'h8, 4'b0100, 0);
    run_op(3'd2, 64'hFF, 64'h0F, 6'd0, 1'b0, 64'hF0, 4'b0100, 5);
    run_op(3'd7, 64'd123, 64'd456, 6'd0, 1'b1, 64'd0, 4'b0100, 0);
    run_op(3'd4, 64'd7, 64'd7, 6'd0, 1'b1, 64'd0, 4'b0101, 0);
    run_op(3'd4, 64'h8000_0000_0000_0000, 64'd1, 6'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011, 0);

    accept_op(3'd4, 64'd9, 64'd4, 6'd0, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid-sub rst out_valid", 64'(bus.out_valid), 64'd0);
    check("mid-sub rst nzvc", 64'(nzvc), 64'd0);
    check("mid-sub rst out_res", bus.out_res, 64'd0);
    check("mid-sub rst in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", 64'(bus.in_ready), 64'd1);
    run_op(3'd3, 64'd2, 64'd2, 6'd0, 1'b0, 64'd4, 4'b0000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
